msg_send_packer: RTL and testbench

- Single-channel transmit-side framer; the mirror of the message receive/analysis path.
- Accepts one header descriptor per frame (src/des id, type, channel, byte length) plus a 128-bit payload stream.
- Emits a framed sequence: header word, payload words, then tail word with sequence number and checksum.
- Writes the frame into a 128-bit FIFO; the FIFO's read side feeds the link whose receive end parses these fields back out.

---
 rtl/msg_send_packer_if.sv | 44 ++++
 rtl/msg_send_packer.sv | 157 +++++++++++++++
 tb/tb_msg_send_packer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_send_packer_if.sv
// msg_send_packer_if
//   Bundles the header request handshake, the payload stream and the FIFO
//   write side of the transmit framer.
//   master : the request/payload source and the FIFO (drives *_i signals)
//   slave  : the framer itself (drives *_o signals)
//   Signal names keep the framer's pin names so the link-side documentation
//   maps one-to-one onto this bundle.
interface msg_send_packer_if;
    // header request
    logic         send_req_i;
    logic [7:0]   src_id_i;
    logic [7:0]   des_id_i;
    logic [7:0]   data_type_i;
    logic [7:0]   data_channel_i;
    logic [15:0]  data_field_len_i;
    logic         send_ack_o;
    // payload stream
    logic         pld_valid_i;
    logic [127:0] pld_data_i;
    logic         pld_ready_o;
    // FIFO write side
    logic         wr_clk_o;
    logic         wr_en_o;
    logic [127:0] wr_dout_o;
    logic         wr_full_i;
    // status
    logic         busy_o;
    logic         done_o;
    logic [31:0]  seq_o;

    modport master (
        output send_req_i, src_id_i, des_id_i, data_type_i, data_channel_i,
               data_field_len_i, pld_valid_i, pld_data_i, wr_full_i,
        input  send_ack_o, pld_ready_o, wr_clk_o, wr_en_o, wr_dout_o,
               busy_o, done_o, seq_o
    );

    modport slave (
        input  send_req_i, src_id_i, des_id_i, data_type_i, data_channel_i,
               data_field_len_i, pld_valid_i, pld_data_i, wr_full_i,
        output send_ack_o, pld_ready_o, wr_clk_o, wr_en_o, wr_dout_o,
               busy_o, done_o, seq_o
    );
endinterface

// File: rtl/msg_send_packer.sv
// msg_send_packer
//   Single-channel transmit framer. Latches one header descriptor per frame,
//   then writes into a 128-bit FIFO:
//     header  {SYNC_HEAD, src, des, type, channel, len, seq, 32'h0}
//     N payload words passed straight through from the payload stream
//     tail    {SYNC_TAIL, len, N, seq, checksum}
//   where N = ceil(len/16) and checksum is the 32-bit wrapping sum of every
//   32-bit lane of every payload word.
// Ports
//   sys_clk_i : system clock (also forwarded as the FIFO write clock)
//   rst_n_i   : synchronous active-low reset; abandons any frame in flight
//   link      : request / payload / FIFO-write bundle (slave side)
module msg_send_packer #(
    parameter logic [15:0] SYNC_HEAD = 16'hEB90,
    parameter logic [15:0] SYNC_TAIL = 16'h09D7
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    msg_send_packer_if.slave  link
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2,
        TAIL    = 2'd3
    } state_t;

    state_t        state_q, state_d;

    logic [7:0]    src_q, des_q, type_q, chan_q;
    logic [15:0]   len_q;
    logic [12:0]   nwords_q;   // 0..4096 payload words
    logic [12:0]   cnt_q;      // payload words written so far
    logic [31:0]   csum_q;
    logic [31:0]   seq_q;
    logic          ack_q;
    logic          done_q;

    logic          wr_en;
    logic [127:0]  wr_dout;
    logic          pld_ready;

    // Word count from the requested byte length; 17-bit sum so 0xFFFF
    // rounds up to 4096 without overflow.
    logic [16:0]   len_round;
    logic [12:0]   nwords_in;
    assign len_round = {1'b0, link.data_field_len_i} + 17'd15;
    assign nwords_in = len_round[16:4];

    logic [31:0]   lane_sum;
    assign lane_sum = link.pld_data_i[31:0]  + link.pld_data_i[63:32] +
                      link.pld_data_i[95:64] + link.pld_data_i[127:96];

    logic          last_word;
    assign last_word = (cnt_q == nwords_q - 13'd1);

    // Next state and FIFO-side outputs. Payload is a zero-latency
    // pass-through, so all write-side outputs are combinational from state
    // and wr_full_i; data is forced to zero on non-write cycles.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_dout   = '0;
        pld_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (link.send_req_i) state_d = HEAD;
            end
            HEAD: begin
                wr_en = !link.wr_full_i;
                if (wr_en) begin
                    wr_dout = {SYNC_HEAD, src_q, des_q, type_q, chan_q,
                               len_q, seq_q, 32'h0};
                    state_d = (nwords_q != 13'd0) ? PAYLOAD : TAIL;
                end
            end
            PAYLOAD: begin
                pld_ready = !link.wr_full_i;
                wr_en     = link.pld_valid_i && !link.wr_full_i;
                if (wr_en) begin
                    wr_dout = link.pld_data_i;
                    if (last_word) state_d = TAIL;
                end
            end
            TAIL: begin
                wr_en = !link.wr_full_i;
                if (wr_en) begin
                    wr_dout = {SYNC_TAIL, len_q, 19'h0, nwords_q, seq_q,
                               csum_q};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            des_q    <= '0;
            type_q   <= '0;
            chan_q   <= '0;
            len_q    <= '0;
            nwords_q <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            seq_q    <= '0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (link.send_req_i) begin
                        src_q    <= link.src_id_i;
                        des_q    <= link.des_id_i;
                        type_q   <= link.data_type_i;
                        chan_q   <= link.data_channel_i;
                        len_q    <= link.data_field_len_i;
                        nwords_q <= nwords_in;
                        cnt_q    <= '0;
                        csum_q   <= '0;
                        ack_q    <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (wr_en) begin
                        csum_q <= csum_q + lane_sum;
                        cnt_q  <= cnt_q + 13'd1;
                    end
                end
                TAIL: begin
                    // seq advances only once the tail is actually in the FIFO
                    if (wr_en) begin
                        seq_q  <= seq_q + 32'd1;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign link.wr_clk_o    = sys_clk_i;
    assign link.wr_en_o     = wr_en;
    assign link.wr_dout_o   = wr_dout;
    assign link.pld_ready_o = pld_ready;
    assign link.send_ack_o  = ack_q;
    assign link.done_o      = done_q;
    assign link.busy_o      = (state_q != IDLE);
    assign link.seq_o       = seq_q;

endmodule

// File: tb/tb_msg_send_packer.sv
// Scoreboard bench for msg_send_packer: the main process pushes expected FIFO
// words into exp_q as each frame is issued; a negedge monitor pops and
// compares on every FIFO write.
module tb_msg_send_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_send_packer_if link();

    msg_send_packer dut (
        .sys_clk_i (clk),
        .rst_n_i   (rst_n),
        .link      (link)
    );

    int total  = 0;
    int passed = 0;

    logic [127:0] exp_q[$];
    logic [127:0] pld_q[$];
    bit           bp = 1'b0;
    int           wr_cnt = 0;
    int           hs_cnt = 0;
    int           done_cnt = 0;
    bit           ready_seen = 1'b0;
    logic [31:0]  m_seq = 32'h0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (link.wr_en_o) begin
                if (link.wr_full_i) fail("wr_en_while_full");
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got %h expected none",
                             link.wr_dout_o);
                end else begin
                    chk("fifo_word", link.wr_dout_o, exp_q.pop_front());
                end
                wr_cnt++;
            end
            if (link.done_o) done_cnt++;
            if (link.pld_ready_o) ready_seen = 1'b1;
        end
    end

    // payload source: handshake sampled at negedge, data advanced after posedge
    initial begin
        bit fire;
        link.pld_valid_i = 1'b0;
        link.pld_data_i  = '0;
        forever begin
            @(negedge clk);
            fire = link.pld_valid_i && link.pld_ready_o && rst_n;
            @(posedge clk);
            #1;
            if (fire && pld_q.size() > 0) begin
                void'(pld_q.pop_front());
                hs_cnt++;
            end
            link.pld_valid_i = (pld_q.size() > 0) &&
                               (!bp || $urandom_range(3) != 0);
            link.pld_data_i  = (pld_q.size() > 0) ? pld_q[0] : '0;
        end
    end

    // FIFO full generator
    initial begin
        link.wr_full_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            link.wr_full_i = bp ? ($urandom_range(2) == 0) : 1'b0;
        end
    end

    task automatic issue(input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] t, input logic [7:0] c,
                         input logic [15:0] len);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        link.src_id_i         = s;
        link.des_id_i         = d;
        link.data_type_i      = t;
        link.data_channel_i   = c;
        link.data_field_len_i = len;
        link.send_req_i       = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (link.send_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_ack", 128'(got), 128'd1);
        @(posedge clk);
        #1;
        link.send_req_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (link.done_o) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 128'(got), 128'd1);
    endtask

    // Reference frame: header, random payload, tail with lane checksum.
    task automatic send_frame(input string name, input logic [7:0] s,
                              input logic [7:0] d, input logic [7:0] t,
                              input logic [7:0] c, input logic [15:0] len);
        int          n;
        logic [31:0] cs = 32'h0;
        logic [127:0] w;
        n = (int'(len) + 15) >> 4;
        exp_q.push_back({16'hEB90, s, d, t, c, len, m_seq, 32'h0});
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            cs = cs + w[31:0] + w[63:32] + w[95:64] + w[127:96];
            exp_q.push_back(w);
            pld_q.push_back(w);
        end
        exp_q.push_back({16'h09D7, len, 32'(n), m_seq, cs});
        issue(s, d, t, c, len);
        wait_done({name, "_done"}, 20000);
        m_seq = m_seq + 32'd1;
        @(negedge clk);
        chk({name, "_seq"}, 128'(link.seq_o), 128'(m_seq));
    endtask

    initial begin
        int base_wr, base_hs, base_done;
        link.send_req_i       = 1'b0;
        link.src_id_i         = '0;
        link.des_id_i         = '0;
        link.data_type_i      = '0;
        link.data_channel_i   = '0;
        link.data_field_len_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",  128'(link.busy_o),      128'd0);
        chk("rst_wr_en", 128'(link.wr_en_o),     128'd0);
        chk("rst_dout",  link.wr_dout_o,         128'd0);
        chk("rst_ready", 128'(link.pld_ready_o), 128'd0);
        chk("rst_ack",   128'(link.send_ack_o),  128'd0);
        chk("rst_done",  128'(link.done_o),      128'd0);
        chk("rst_seq",   128'(link.seq_o),       128'd0);
        chk("wr_clk_low", 128'(link.wr_clk_o),   128'd0);

        // basic frame, hand-computed words
        base_done = done_cnt;
        base_wr   = wr_cnt;
        exp_q.push_back(128'hEB90_1122_0305_0020_00000000_00000000);
        exp_q.push_back(128'h00000001_00000001_00000001_00000001);
        exp_q.push_back(128'h00000001_00000001_00000001_00000001);
        exp_q.push_back(128'h09D7_0020_00000002_00000000_00000008);
        pld_q.push_back(128'h00000001_00000001_00000001_00000001);
        pld_q.push_back(128'h00000001_00000001_00000001_00000001);
        issue(8'h11, 8'h22, 8'h03, 8'h05, 16'd32);
        wait_done("basic_done", 200);
        m_seq = 32'd1;
        repeat (3) @(negedge clk);
        chk("basic_seq",    128'(link.seq_o),         128'd1);
        chk("basic_dones",  128'(done_cnt - base_done), 128'd1);
        chk("basic_writes", 128'(wr_cnt - base_wr),   128'd4);
        chk("basic_idle",   128'(link.busy_o),        128'd0);

        // zero length: header + tail only, payload never requested
        ready_seen = 1'b0;
        base_wr = wr_cnt;
        send_frame("len0", 8'hA1, 8'hB2, 8'h01, 8'h00, 16'd0);
        chk("len0_writes", 128'(wr_cnt - base_wr), 128'd2);
        chk("len0_noready", 128'(ready_seen), 128'd0);

        // rounding
        base_hs = hs_cnt;
        send_frame("len17", 8'h01, 8'h02, 8'h03, 8'h04, 16'd17);
        chk("len17_words", 128'(hs_cnt - base_hs), 128'd2);
        base_hs = hs_cnt;
        send_frame("len16", 8'h05, 8'h06, 8'h07, 8'h08, 16'd16);
        chk("len16_words", 128'(hs_cnt - base_hs), 128'd1);
        base_hs = hs_cnt;
        base_wr = wr_cnt;
        send_frame("lenmax", 8'hFF, 8'hEE, 8'hDD, 8'hCC, 16'hFFFF);
        chk("lenmax_words",  128'(hs_cnt - base_hs), 128'd4096);
        chk("lenmax_writes", 128'(wr_cnt - base_wr), 128'd4098);

        // backpressure: random full and payload-valid gaps
        bp = 1'b1;
        base_hs = hs_cnt;
        send_frame("bp50", 8'h31, 8'h32, 8'h33, 8'h34, 16'd50);
        chk("bp50_words", 128'(hs_cnt - base_hs), 128'd4);
        base_hs = hs_cnt;
        send_frame("bp0", 8'h41, 8'h42, 8'h43, 8'h44, 16'd0);
        chk("bp0_words", 128'(hs_cnt - base_hs), 128'd0);
        base_hs = hs_cnt;
        send_frame("bp129", 8'h51, 8'h52, 8'h53, 8'h54, 16'd129);
        chk("bp129_words", 128'(hs_cnt - base_hs), 128'd9);
        bp = 1'b0;
        repeat (2) @(posedge clk);

        // sequence wrap
        @(posedge clk);
        #1 force dut.seq_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.seq_q;
        m_seq = 32'hFFFF_FFFF;
        send_frame("wrap", 8'h61, 8'h62, 8'h63, 8'h64, 16'd20);
        chk("wrap_seq_zero", 128'(link.seq_o), 128'd0);

        // reset after payload word 1 of 4
        begin
            logic [127:0] w1;
            bit reached = 1'b0;
            w1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
            base_wr = wr_cnt;
            exp_q.push_back({16'hEB90, 8'h71, 8'h72, 8'h73, 8'h74, 16'd64,
                             m_seq, 32'h0});
            exp_q.push_back(w1);
            pld_q.push_back(w1);
            issue(8'h71, 8'h72, 8'h73, 8'h74, 16'd64);
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                if (wr_cnt - base_wr >= 2) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("midrst_reached", 128'(reached), 128'd1);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            chk("midrst_busy",  128'(link.busy_o),      128'd0);
            chk("midrst_wr_en", 128'(link.wr_en_o),     128'd0);
            chk("midrst_dout",  link.wr_dout_o,         128'd0);
            chk("midrst_ready", 128'(link.pld_ready_o), 128'd0);
            chk("midrst_seq",   128'(link.seq_o),       128'(m_seq));
            repeat (5) @(negedge clk);
            chk("midrst_no_tail", 128'(wr_cnt - base_wr), 128'd2);
        end
        base_hs = hs_cnt;
        send_frame("after_rst", 8'h81, 8'h82, 8'h83, 8'h84, 16'd64);
        chk("after_rst_words", 128'(hs_cnt - base_hs), 128'd4);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

endmodule
